move_link_tx: RTL



---
 rtl/move_link_pkg.sv | 44 ++++
 rtl/move_link_tx_if.sv | 35 +++
 rtl/move_link_tx_uart_byte_tx.sv | 156 +++++++++++++++
 rtl/move_link_tx.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/move_link_pkg.sv
// -----------------------------------------------------------------------------
// move_link_pkg
// Shared definitions for both sides of the inter-board move link.
// Contents:
//   - state_t      : per-bit frame states plus the inter-packet GAP state
//   - pkt_state_t  : packet sequencer states of the transmitter
//   - MOVE_PASS, BOARD_MAX, SYNC_BYTE_DEFAULT
//   - chk_byte()   : packet checksum byte
//   - move_is_legal(): move encoding check
// Build option: MOVE_LINK_PARITY_EN adds the ST_PARITY frame state (8E1).
// -----------------------------------------------------------------------------
package move_link_pkg;

  localparam logic [7:0] MOVE_PASS         = 8'hFF;
  localparam logic [3:0] BOARD_MAX         = 4'd8;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef MOVE_LINK_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_GAP
  } state_t;

  typedef enum logic [1:0] {
    PKT_IDLE,
    PKT_SEND,
    PKT_GAP
  } pkt_state_t;

  function automatic logic [7:0] chk_byte(input logic [7:0] mv, input logic [7:0] sync);
    return sync ^ mv;
  endfunction

  // A pass, or a square with row and column both inside the board.
  function automatic logic move_is_legal(input logic [7:0] mv);
    return (mv == MOVE_PASS) || ((mv[7:4] <= BOARD_MAX) && (mv[3:0] <= BOARD_MAX));
  endfunction

endpackage

// File: rtl/move_link_tx_if.sv
// -----------------------------------------------------------------------------
// move_link_tx_if
// Game-FSM side of the move link transmitter.
// Handshake: tx_ready is a single-cycle request qualifying move; the
// transmitter answers with registered one-cycle pulses (done, overrun,
// bad_move) and a level busy. There is no ready/backpressure: a request
// that cannot be queued is dropped and reported via overrun.
// Signals:
//   tx_ready  game -> tx   request to send move
//   move      game -> tx   8-bit move (row [7:4], col [3:0], 8'hFF = pass)
//   tx_out    tx -> line   serial output, idles high
//   busy      tx -> game   packet(s) in flight
//   done      tx -> game   CHK stop bit completed
//   overrun   tx -> game   request dropped, holding buffer full
//   bad_move  tx -> game   request rejected, illegal encoding
// -----------------------------------------------------------------------------
interface move_link_tx_if;
  logic       tx_ready;
  logic [7:0] move;
  logic       tx_out;
  logic       busy;
  logic       done;
  logic       overrun;
  logic       bad_move;

  modport master (
    output tx_ready, move,
    input  tx_out, busy, done, overrun, bad_move
  );

  modport slave (
    input  tx_ready, move,
    output tx_out, busy, done, overrun, bad_move
  );
endinterface

// File: rtl/move_link_tx_uart_byte_tx.sv
// -----------------------------------------------------------------------------
// move_link_tx_uart_byte_tx
// Serialises one byte LSB first: start(0), 8 data, [parity], stop(1); every
// bit lasts CLKS_PER_BIT clocks.
// Ports:
//   clk_in, rst_in_n  clock, asynchronous active-low reset
//   i_start           load i_data; honoured in ST_IDLE or on the last cycle
//                     of ST_STOP (back-to-back bytes without idle time)
//   i_data            byte to send
//   o_tx              registered serial output
//   o_busy            frame in progress
//   o_done            high during the last cycle of the stop bit
//   o_state           current frame state (debug)
// Build option: MOVE_LINK_PARITY_EN inserts an even parity bit (8E1).
// -----------------------------------------------------------------------------
module move_link_tx_uart_byte_tx
  import move_link_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk_in,
  input  logic       rst_in_n,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done,
  output state_t     o_state
);

  localparam int unsigned   CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_clk_cnt, w_clk_nxt;
  logic [2:0]    r_bit_cnt, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_tx, w_tx_nxt;
  logic          w_bit_end;
  logic          w_done;
  logic          w_load;
`ifdef MOVE_LINK_PARITY_EN
  logic          r_par, w_par_nxt;
`endif

  assign w_bit_end = (r_clk_cnt == CLK_LAST);

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_state   <= ST_IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
`ifdef MOVE_LINK_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_clk_cnt <= w_clk_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
`ifdef MOVE_LINK_PARITY_EN
      r_par     <= w_par_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clk_nxt   = w_bit_end ? '0 : r_clk_cnt + 1'b1;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_done      = 1'b0;
    w_load      = 1'b0;
`ifdef MOVE_LINK_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      ST_IDLE: begin
        w_clk_nxt = '0;
        w_tx_nxt  = 1'b1;
        w_load    = i_start;
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_nxt = ST_DATA;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_shift[0];
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          if (r_bit_cnt == 3'd7) begin
            w_bit_nxt   = '0;
`ifdef MOVE_LINK_PARITY_EN
            w_state_nxt = ST_PARITY;
            w_tx_nxt    = r_par;
`else
            w_state_nxt = ST_STOP;
            w_tx_nxt    = 1'b1;
`endif
          end else begin
            // r_shift[1] is the next data bit once the register shifts.
            w_bit_nxt   = r_bit_cnt + 1'b1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
          end
        end
      end
`ifdef MOVE_LINK_PARITY_EN
      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = ST_STOP;
          w_tx_nxt    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (w_bit_end) begin
          w_done = 1'b1;
          if (i_start) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_tx_nxt    = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase

    // Loading drives the start bit from the very next edge.
    if (w_load) begin
      w_state_nxt = ST_START;
      w_clk_nxt   = '0;
      w_bit_nxt   = '0;
      w_shift_nxt = i_data;
      w_tx_nxt    = 1'b0;
`ifdef MOVE_LINK_PARITY_EN
      w_par_nxt   = ^i_data;
`endif
    end
  end

  assign o_tx    = r_tx;
  assign o_busy  = (r_state != ST_IDLE);
  assign o_done  = w_done;
  assign o_state = r_state;

endmodule

// File: rtl/move_link_tx.sv
// -----------------------------------------------------------------------------
// move_link_tx
// Transmit side of the inter-board move link. A legal move requested with
// tx_ready is framed as SYNC, MOVE, CHK (= SYNC ^ MOVE) and sent UART-style,
// followed by GAP_BITS idle bit-times. One request arriving while busy is
// held and sent right after the current packet's gap.
// Ports:
//   clk_in       system clock
//   rst_in_n     asynchronous active-low reset (clears active and held move)
//   link         move_link_tx_if.slave: tx_ready, move, tx_out, busy, done,
//                overrun, bad_move
//   o_dbg_state  frame/packet state (ST_IDLE .. ST_GAP) for observation
// Parameters: CLKS_PER_BIT (>=2), GAP_BITS (>=0), SYNC_BYTE.
// Build option: MOVE_LINK_PARITY_EN selects 8E1 frames (33 bit-times/packet).
// -----------------------------------------------------------------------------
module move_link_tx
  import move_link_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned GAP_BITS     = 2,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic           clk_in,
  input  logic           rst_in_n,
  move_link_tx_if.slave  link,
  output state_t         o_dbg_state
);

  localparam int unsigned   CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam int unsigned   GW       = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  pkt_state_t    r_pkt_state, w_state_nxt;
  logic [1:0]    r_byte_idx, w_idx_nxt;
  logic [7:0]    r_move, w_move_nxt;
  logic [7:0]    r_pend, w_pend_nxt;
  logic          r_pend_vld, w_pend_vld_nxt;
  logic [CW-1:0] r_gap_clk, w_gap_clk_nxt;
  logic [GW-1:0] r_gap_bit, w_gap_bit_nxt;
  logic          r_done, r_overrun, r_bad;

  logic          w_legal, w_req;
  logic          w_start, w_overrun;
  logic [7:0]    w_byte;
  logic          w_gap_clk_end, w_last_byte, w_pkt_tail, w_pkt_end;
  logic          w_uart_tx, w_uart_busy, w_uart_done;
  state_t        w_uart_state;

  assign w_legal       = move_is_legal(link.move);
  assign w_req         = link.tx_ready && w_legal;
  assign w_gap_clk_end = (r_gap_clk == CLK_LAST);
  assign w_last_byte   = (r_byte_idx == 2'd2);
  // CHK stop bit is in its final cycle.
  assign w_pkt_tail    = (r_pkt_state == PKT_SEND) && w_uart_done && w_last_byte;
  // Packet slot (including gap) is over; with no gap that is the CHK stop end.
  assign w_pkt_end     = (GAP_BITS == 0) ? w_pkt_tail
                       : ((r_pkt_state == PKT_GAP) && w_gap_clk_end && (r_gap_bit == GAP_LAST));

  move_link_tx_uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk_in   (clk_in),
    .rst_in_n (rst_in_n),
    .i_start  (w_start),
    .i_data   (w_byte),
    .o_tx     (w_uart_tx),
    .o_busy   (w_uart_busy),
    .o_done   (w_uart_done),
    .o_state  (w_uart_state)
  );

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_pkt_state <= PKT_IDLE;
      r_byte_idx  <= '0;
      r_move      <= '0;
      r_pend      <= '0;
      r_pend_vld  <= 1'b0;
      r_gap_clk   <= '0;
      r_gap_bit   <= '0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
      r_bad       <= 1'b0;
    end else begin
      r_pkt_state <= w_state_nxt;
      r_byte_idx  <= w_idx_nxt;
      r_move      <= w_move_nxt;
      r_pend      <= w_pend_nxt;
      r_pend_vld  <= w_pend_vld_nxt;
      r_gap_clk   <= w_gap_clk_nxt;
      r_gap_bit   <= w_gap_bit_nxt;
      r_done      <= w_pkt_tail;
      r_overrun   <= w_overrun;
      r_bad       <= link.tx_ready && !w_legal;
    end
  end

  always_comb begin
    w_state_nxt    = r_pkt_state;
    w_idx_nxt      = r_byte_idx;
    w_move_nxt     = r_move;
    w_pend_nxt     = r_pend;
    w_pend_vld_nxt = r_pend_vld;
    w_gap_clk_nxt  = r_gap_clk;
    w_gap_bit_nxt  = r_gap_bit;
    w_start        = 1'b0;
    w_byte         = SYNC_BYTE;
    w_overrun      = 1'b0;

    case (r_pkt_state)
      PKT_IDLE: begin
        if (w_req) begin
          w_start     = 1'b1;
          w_move_nxt  = link.move;
          w_idx_nxt   = '0;
          w_state_nxt = PKT_SEND;
        end
      end
      PKT_SEND: begin
        if (w_uart_done) begin
          if (!w_last_byte) begin
            w_start   = 1'b1;
            w_idx_nxt = r_byte_idx + 2'd1;
            w_byte    = (r_byte_idx == 2'd0) ? r_move : chk_byte(r_move, SYNC_BYTE);
          end else if (GAP_BITS != 0) begin
            w_state_nxt   = PKT_GAP;
            w_idx_nxt     = '0;
            w_gap_clk_nxt = '0;
            w_gap_bit_nxt = '0;
          end
        end
      end
      PKT_GAP: begin
        w_gap_clk_nxt = w_gap_clk_end ? '0 : r_gap_clk + 1'b1;
        if (w_gap_clk_end) begin
          w_gap_bit_nxt = r_gap_bit + 1'b1;
        end
      end
      default: w_state_nxt = PKT_IDLE;
    endcase

    if (w_pkt_end) begin
      w_idx_nxt = '0;
      if (r_pend_vld) begin
        // Pop the held move; a request in this same cycle refills the slot.
        w_start        = 1'b1;
        w_move_nxt     = r_pend;
        w_state_nxt    = PKT_SEND;
        w_pend_vld_nxt = w_req;
        w_pend_nxt     = link.move;
      end else if (w_req) begin
        w_start     = 1'b1;
        w_move_nxt  = link.move;
        w_state_nxt = PKT_SEND;
      end else begin
        w_state_nxt = PKT_IDLE;
      end
    end else if ((r_pkt_state != PKT_IDLE) && w_req) begin
      if (!r_pend_vld) begin
        w_pend_vld_nxt = 1'b1;
        w_pend_nxt     = link.move;
      end else begin
        w_overrun = 1'b1;
      end
    end
  end

  assign link.tx_out   = w_uart_tx;
  assign link.busy     = (r_pkt_state != PKT_IDLE);
  assign link.done     = r_done;
  assign link.overrun  = r_overrun;
  assign link.bad_move = r_bad;

  assign o_dbg_state = (r_pkt_state == PKT_GAP) ? ST_GAP
                     : (w_uart_busy ? w_uart_state : ST_IDLE);

endmodule
